dedicated_counter_adc_sched: RTL and testbench

- Parametrised successor to the fixed 16-channel dedicated counter/ADC integrator.
- Counts photon edges on NUM_COUNTERS inputs and accumulates samples from NUM_ADC ADC channels over a programmable integration interval.
- At each interval boundary it snapshots all results and serialises them as tagged 64-bit words into the downstream FIFO multiplexer.
- Honours fifo_full backpressure and reports overrun when the next boundary arrives before all words are emitted.

---
 rtl/dedicated_counter_adc_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_dedicated_counter_adc_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dedicated_counter_adc_sched.sv
// Photon counters and ADC integrators; snapshots each interval and emits tagged words.
// Define DEDICATED_ADC_MINMAX_EN to add per-ADC min/max tracking and type-3 words.
module dedicated_counter_adc_sched #(
    parameter int NUM_COUNTERS = 16,
    parameter int NUM_ADC      = 16,
    parameter int ADC_WIDTH    = 16,
    parameter int COUNT_WIDTH  = 24,
    parameter int TIME_WIDTH   = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_COUNTERS-1:0]        count_input,
    input  logic [NUM_COUNTERS-1:0]        count_enable,
    input  logic [NUM_ADC-1:0]             adc_enable,
    input  logic [NUM_ADC*ADC_WIDTH-1:0]   adcdata,
    input  logic [NUM_ADC-1:0]             adcready,
    input  logic [39:0]                    tdc_count,
    input  logic [TIME_WIDTH-1:0]          update_time,
    input  logic                           fifo_full,
    output logic [63:0]                    data_out,
    output logic                           data_available,
    output logic                           overrun
);

`ifdef DEDICATED_ADC_MINMAX_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif
    localparam int NSLOT = NUM_COUNTERS + NUM_ADC * K + 1;
    localparam int MARK  = NSLOT - 1;

    logic [NUM_COUNTERS-1:0] cin_q1;
    logic [NUM_COUNTERS-1:0] cin_q2;
    logic [NUM_COUNTERS-1:0] cev;
    logic [TIME_WIDTH-1:0]   timer_q;
    logic [TIME_WIDTH-1:0]   timer_d;
    logic                    bnd;
    logic [39:0]             tdc_sh_q;
    logic [18:0]             idx_q;
    logic                    ovr_q;
    logic                    ovr_mark_q;
    logic [NSLOT-1:0]        pend_q;
    logic [NSLOT-1:0]        pend_d;
    logic [NSLOT-1:0]        pend_set;
    logic [NSLOT-1:0]        gnt;
    logic [63:0]             slot_w [NSLOT];
    logic [63:0]             word;
    logic [63:0]             dout_q;
    logic                    vld_q;
    logic                    load;

    assign cev = cin_q1 & ~cin_q2;

    // A timer past a lowered update_time is caught by the >= compare.
    assign bnd = (update_time != '0) &&
                 (timer_q >= update_time - TIME_WIDTH'(1));

    always_comb begin
        timer_d = timer_q + TIME_WIDTH'(1);
        if (update_time == '0 || bnd) begin
            timer_d = '0;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        logic                   hit;
        logic [COUNT_WIDTH-1:0] cnt_q;
        logic [COUNT_WIDTH-1:0] cnt_sh_q;

        assign hit = cev[i] & count_enable[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= '0;
                cnt_sh_q <= '0;
            end else if (bnd) begin
                cnt_sh_q <= cnt_q;
                cnt_q    <= hit ? COUNT_WIDTH'(1) : '0;
            end else if (hit && cnt_q != '1) begin
                cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
        end

        assign pend_set[i] = count_enable[i];
        assign slot_w[i]   = {4'h1, 4'(i), 56'(cnt_sh_q)};
    end

    for (genvar i = 0; i < NUM_ADC; i++) begin : g_adc
        logic [ADC_WIDTH-1:0] smp;
        logic                 hit;
        logic [40:0]          acc;
        logic [39:0]          sum_q;
        logic [39:0]          sum_sh_q;
        logic [15:0]          ns_q;
        logic [15:0]          ns_sh_q;

        assign smp = adcdata[i*ADC_WIDTH +: ADC_WIDTH];
        assign hit = adcready[i] & adc_enable[i];
        assign acc = {1'b0, sum_q} + 41'(smp);

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q    <= '0;
                sum_sh_q <= '0;
                ns_q     <= '0;
                ns_sh_q  <= '0;
            end else if (bnd) begin
                sum_sh_q <= sum_q;
                ns_sh_q  <= ns_q;
                sum_q    <= hit ? 40'(smp) : '0;
                ns_q     <= hit ? 16'd1 : '0;
            end else if (hit) begin
                sum_q <= acc[40] ? '1 : acc[39:0];
                if (ns_q != '1) begin
                    ns_q <= ns_q + 16'd1;
                end
            end
        end

        assign pend_set[NUM_COUNTERS + i*K] = adc_enable[i];
        assign slot_w[NUM_COUNTERS + i*K]   = {4'h2, 4'(i), ns_sh_q, sum_sh_q};

`ifdef DEDICATED_ADC_MINMAX_EN
        logic [ADC_WIDTH-1:0] mn_q;
        logic [ADC_WIDTH-1:0] mx_q;
        logic [ADC_WIDTH-1:0] mn_sh_q;
        logic [ADC_WIDTH-1:0] mx_sh_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                mn_q    <= '1;
                mx_q    <= '0;
                mn_sh_q <= '1;
                mx_sh_q <= '0;
            end else if (bnd) begin
                mn_sh_q <= mn_q;
                mx_sh_q <= mx_q;
                mn_q    <= hit ? smp : '1;
                mx_q    <= hit ? smp : '0;
            end else if (hit) begin
                if (smp < mn_q) begin
                    mn_q <= smp;
                end
                if (smp > mx_q) begin
                    mx_q <= smp;
                end
            end
        end

        assign pend_set[NUM_COUNTERS + i*K + 1] = adc_enable[i];
        assign slot_w[NUM_COUNTERS + i*K + 1] =
            {4'h3, 4'(i), 8'h0, 24'(mx_sh_q), 24'(mn_sh_q)};
`endif
    end

    assign pend_set[MARK] = 1'b1;
    assign slot_w[MARK]   = {4'hF, ovr_mark_q, idx_q, tdc_sh_q};

    // Lowest pending slot wins, giving counter, ADC, marker order.
    assign gnt  = pend_q & (~pend_q + NSLOT'(1));
    assign load = !bnd && (pend_q != '0) && (!vld_q || !fifo_full);

    always_comb begin
        word = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (gnt[s]) begin
                word = word | slot_w[s];
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (bnd) begin
            pend_d = pend_set;
        end else if (load) begin
            pend_d = pend_q & ~gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cin_q1     <= '0;
            cin_q2     <= '0;
            timer_q    <= '0;
            tdc_sh_q   <= '0;
            idx_q      <= '0;
            ovr_q      <= 1'b0;
            ovr_mark_q <= 1'b0;
            pend_q     <= '0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            cin_q1  <= count_input;
            cin_q2  <= cin_q1;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            if (bnd) begin
                tdc_sh_q   <= tdc_count;
                idx_q      <= idx_q + 19'd1;
                ovr_mark_q <= |pend_q;
                if (|pend_q) begin
                    ovr_q <= 1'b1;
                end
            end
            // The output register holds its word until the FIFO accepts it.
            if (load) begin
                dout_q <= word;
                vld_q  <= 1'b1;
            end else if (!fifo_full) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign data_out       = dout_q;
    assign data_available = vld_q & ~fifo_full;
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_dedicated_counter_adc_sched.sv
// Directed bench for dedicated_counter_adc_sched: vector table plus corner sequences.
// Honours DEDICATED_ADC_MINMAX_EN when the design is built with it.
module tb_dedicated_counter_adc_sched;

`ifdef DEDICATED_ADC_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    localparam logic [39:0] T = 40'hA5_1234_5678;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  count_input;
    logic [15:0]  count_enable;
    logic [15:0]  adc_enable;
    logic [255:0] adcdata;
    logic [15:0]  adcready;
    logic [39:0]  tdc_count;
    logic [47:0]  update_time;
    logic         fifo_full;
    logic [63:0]  data_out;
    logic         data_available;
    logic         overrun;

    dedicated_counter_adc_sched dut (
        .clk(clk), .rst(rst),
        .count_input(count_input), .count_enable(count_enable),
        .adc_enable(adc_enable), .adcdata(adcdata), .adcready(adcready),
        .tdc_count(tdc_count), .update_time(update_time),
        .fifo_full(fifo_full), .data_out(data_out),
        .data_available(data_available), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          upd;
        logic [15:0] cen;
        logic [15:0] aen;
        int          np;
        int          ns;
        logic [15:0] smp;
        int          fstart;
        int          flen;
        int          ncyc;
        logic [55:0] ecnt;
        logic [15:0] ens;
        logic [39:0] esum;
        int          efirst;
    } vec_t;

    vec_t        tv[5];
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    int          cyc;
    int          first_cyc;
    int          viol;
    int          n_pass;
    int          n_tot;

    always @(negedge clk) begin
        if (data_available) begin
            if (fifo_full) viol++;
            if (got.size() == 0) first_cyc = cyc;
            got.push_back(data_out);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int upd, input logic [15:0] cen, input logic [15:0] aen);
        rst = 1'b1;
        count_input = '0;
        adcready = '0;
        adcdata = '0;
        fifo_full = 1'b0;
        tdc_count = T;
        update_time = 48'(upd);
        count_enable = cen;
        adc_enable = aen;
        step();
        step();
        got.delete();
        exp_q.delete();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " data_out"}, data_out, 64'h0);
        chk({nm, " data_available"}, 64'(data_available), 64'h0);
        chk({nm, " overrun"}, 64'(overrun), 64'h0);
    endtask

    function automatic logic [63:0] cw(input int ch, input logic [55:0] v);
        return {4'h1, 4'(ch), v};
    endfunction

    function automatic logic [63:0] aw(input int ch, input logic [15:0] n, input logic [39:0] s);
        return {4'h2, 4'(ch), n, s};
    endfunction

    function automatic logic [63:0] mw(input int ch, input logic [15:0] mx, input logic [15:0] mn);
        return {4'h3, 4'(ch), 8'h0, 8'h0, mx, 8'h0, mn};
    endfunction

    function automatic logic [63:0] mk(input logic ov, input logic [18:0] idx);
        return {4'hF, ov, idx, T};
    endfunction

    task automatic cmp_words(input string nm);
        chk({nm, " word count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s word%0d", nm, i), got[i], exp_q[i]);
    endtask

    task automatic run_vec(input vec_t v);
        apply_reset(v.upd, v.cen, v.aen);
        adcdata = {16{v.smp}};
        for (int c = 0; c < v.ncyc; c++) begin
            count_input = (c >= 2 && c < 2 + 2*v.np && (c % 2) == 0) ? 16'hFFFF : 16'h0;
            adcready = (c >= 2 && c < 2 + v.ns) ? 16'hFFFF : 16'h0;
            fifo_full = (c >= v.fstart && c < v.fstart + v.flen);
            step();
        end
        count_input = '0;
        adcready = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 16; i++)
            if (v.cen[i]) exp_q.push_back(cw(i, v.ecnt));
        for (int i = 0; i < 16; i++)
            if (v.aen[i]) begin
                exp_q.push_back(aw(i, v.ens, v.esum));
                if (MM) exp_q.push_back(v.ns > 0 ? mw(i, v.smp, v.smp) : mw(i, 16'h0, 16'hFFFF));
            end
        exp_q.push_back(mk(1'b0, 19'd1));
        cmp_words(v.nm);
        chk({v.nm, " first word cycle"}, 64'(first_cyc), 64'(v.efirst));
    endtask

    initial begin
        n_pass = 0;
        n_tot = 0;
        viol = 0;
        cyc = 0;
        first_cyc = -1;

        tv[0] = '{"cnt5", 32, 16'h0001, 16'h0000, 5, 0, 16'h0000, -1, 0, 60,
                  56'd5, 16'd0, 40'h0, 33};
        tv[1] = '{"adc15", 32, 16'h0000, 16'h0001, 0, 15, 16'h0042, -1, 0, 60,
                  56'd0, 16'd15, 40'h3DE, 33};
        tv[2] = '{"none", 32, 16'h0000, 16'h0000, 0, 0, 16'h0000, -1, 0, 60,
                  56'd0, 16'd0, 40'h0, 33};
        tv[3] = '{"mixed", 32, 16'h8001, 16'h0003, 3, 4, 16'hFFFF, -1, 0, 60,
                  56'd3, 16'd4, 40'h3FFFC, 33};
        tv[4] = '{"backpressure", 64, 16'h000F, 16'h0003, 2, 0, 16'h0000, 63, 10, 120,
                  56'd2, 16'd0, 40'h0, 73};

        apply_reset(32, 16'h0, 16'h0);
        chk_reset("reset");

        for (int k = 0; k < 5; k++) run_vec(tv[k]);
        chk("strobe while full", 64'(viol), 64'h0);

        // Level held high counts once; later intervals report zero.
        apply_reset(32, 16'h0008, 16'h0);
        for (int c = 0; c < 92; c++) begin
            count_input = (c >= 2 && c < 102) ? 16'h0008 : 16'h0;
            step();
        end
        exp_q.push_back(cw(3, 56'd1));
        exp_q.push_back(mk(1'b0, 19'd1));
        exp_q.push_back(cw(3, 56'd0));
        exp_q.push_back(mk(1'b0, 19'd2));
        cmp_words("held level");

        // Events at cycles 27, 29 and 31; the boundary-cycle event moves to interval 2.
        apply_reset(32, 16'h0001, 16'h0);
        for (int c = 0; c < 92; c++) begin
            count_input = (c == 26 || c == 28 || c == 30) ? 16'h0001 : 16'h0;
            step();
        end
        count_input = '0;
        exp_q.push_back(cw(0, 56'd2));
        exp_q.push_back(mk(1'b0, 19'd1));
        exp_q.push_back(cw(0, 56'd1));
        exp_q.push_back(mk(1'b0, 19'd2));
        cmp_words("boundary event");

        // Boundaries at cycles 3,7,..,39 give index 10 with the overrun bit set.
        apply_reset(4, 16'hFFFF, 16'hFFFF);
        for (int c = 0; c < 40; c++) step();
        chk("overrun set", 64'(overrun), 64'h1);
        update_time = '0;
        got.delete();
        for (int c = 0; c < 70; c++) step();
        for (int i = 0; i < 16; i++) exp_q.push_back(cw(i, 56'd0));
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(aw(i, 16'd0, 40'h0));
            if (MM) exp_q.push_back(mw(i, 16'h0, 16'hFFFF));
        end
        exp_q.push_back(mk(1'b1, 19'd10));
        cmp_words("overrun");
        chk("overrun sticky", 64'(overrun), 64'h1);

        // Reset in the middle of emission leaves nothing behind.
        apply_reset(32, 16'hFFFF, 16'h0);
        for (int c = 0; c < 36; c++) step();
        rst = 1'b1;
        step();
        chk_reset("mid reset");
        got.delete();
        rst = 1'b0;
        update_time = '0;
        for (int c = 0; c < 40; c++) step();
        chk("mid reset words", 64'(got.size()), 64'h0);

`ifdef DEDICATED_ADC_MINMAX_EN
        apply_reset(32, 16'h0, 16'h0002);
        for (int c = 0; c < 60; c++) begin
            adcready = (c >= 2 && c < 5) ? 16'h0002 : 16'h0;
            adcdata[16 +: 16] = (c == 2) ? 16'd5 : (c == 3) ? 16'd9 : 16'd2;
            step();
        end
        adcready = '0;
        exp_q.push_back(aw(1, 16'd3, 40'h10));
        exp_q.push_back(mw(1, 16'd9, 16'd2));
        exp_q.push_back(mk(1'b0, 19'd1));
        cmp_words("minmax");
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
